ilm_iter_mult: RTL



---
 rtl/ilm_pkg.sv | 30 +++
 rtl/ilm_lod.sv | 23 ++
 rtl/ilm_iter_mult.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ilm_pkg.sv
// Shared types and helpers for the iterative logarithmic multiplier.
package ilm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((32'd1 << r) < v)) r = r + 1;
    return r;
  endfunction

  // Index width for a leading-one detector over a WIDTH-bit word (never zero bits).
  function automatic int unsigned idx_w(input int unsigned width);
    return (width > 1) ? clog2(width) : 1;
  endfunction

  // A zero request still performs one iteration; over-large requests saturate.
  function automatic int unsigned clamp_limit(input int unsigned lim, input int unsigned max_iter);
    if (lim == 0) return 1;
    if (lim > max_iter) return max_iter;
    return lim;
  endfunction

endpackage

// File: rtl/ilm_lod.sv
// Combinational leading-one detector: index of the highest set bit plus an all-zero flag.
module ilm_lod
  import ilm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned LW = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] v,
  output logic [LW-1:0]    idx_c,
  output logic             zero_c
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx_c = LW'(i);
    end
  end

  assign zero_c = ~|v;

endmodule

// File: rtl/ilm_iter_mult.sv
// Sequential iterative logarithmic multiplier with a per-operation iteration limit.
module ilm_iter_mult
  import ilm_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_ITER = WIDTH,
  localparam int unsigned ITER_W  = clog2(MAX_ITER + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic [ITER_W-1:0]    iter_limit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 exact,
  output logic [ITER_W-1:0]    iters_used
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned LW = idx_w(WIDTH);
  localparam int unsigned SW = LW + 1;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a, a_nxt, b, b_nxt;
  logic [PW-1:0]     acc, acc_nxt;
  logic [ITER_W-1:0] cnt, cnt_nxt, lim, lim_nxt;
  logic              exact_nxt, out_valid_nxt, in_ready_nxt;

  logic [LW-1:0]     ka, kb;
  logic              za, zb;
  logic [WIDTH-1:0]  ra, rb;
  logic [SW-1:0]     ksum;
  logic [PW-1:0]     term;

  ilm_lod #(.WIDTH(WIDTH)) u_lod_a (.v(a), .idx_c(ka), .zero_c(za));
  ilm_lod #(.WIDTH(WIDTH)) u_lod_b (.v(b), .idx_c(kb), .zero_c(zb));

  // One ILM term: 2^(k1+k2) + ra*2^k2 + rb*2^k1, where ra/rb are the residues below the leading ones.
  always_comb begin
    ra   = a ^ (WIDTH'(1) << ka);
    rb   = b ^ (WIDTH'(1) << kb);
    ksum = SW'(ka) + SW'(kb);
    term = (PW'(1) << ksum) + (PW'(ra) << kb) + (PW'(rb) << ka);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      cnt       <= '0;
      lim       <= '0;
      exact     <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      lim       <= lim_nxt;
      exact     <= exact_nxt;
      out_valid <= out_valid_nxt;
      in_ready  <= in_ready_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    a_nxt         = a;
    b_nxt         = b;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    lim_nxt       = lim;
    exact_nxt     = exact;
    out_valid_nxt = out_valid;
    in_ready_nxt  = in_ready;

    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_nxt        = x;
          b_nxt        = y;
          acc_nxt      = '0;
          cnt_nxt      = '0;
          lim_nxt      = ITER_W'(clamp_limit(32'(iter_limit), MAX_ITER));
          exact_nxt    = 1'b0;
          in_ready_nxt = 1'b0;
          if ((x == '0) || (y == '0)) begin
            state_nxt     = DONE;
            exact_nxt     = 1'b1;
            out_valid_nxt = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end

      BUSY: begin
        // A zero residue here means the product is already complete; never add a bogus term.
        if (za || zb) begin
          state_nxt     = DONE;
          exact_nxt     = 1'b1;
          out_valid_nxt = 1'b1;
        end else begin
          acc_nxt = acc + term;
          a_nxt   = ra;
          b_nxt   = rb;
          cnt_nxt = cnt + ITER_W'(1);
          if ((ra == '0) || (rb == '0)) begin
            state_nxt     = DONE;
            exact_nxt     = 1'b1;
            out_valid_nxt = 1'b1;
          end else if (cnt_nxt == lim) begin
            state_nxt     = DONE;
            exact_nxt     = 1'b0;
            out_valid_nxt = 1'b1;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt     = IDLE;
        out_valid_nxt = 1'b0;
        in_ready_nxt  = 1'b1;
      end
    endcase
  end

  assign p          = acc;
  assign iters_used = cnt;

endmodule
